// File: rtl/counting_pkg.sv
// ---------------------------------------------------------------------------
// counting_pkg : shared types for the counting_arb symbol recognizer.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counting_pkg;

  localparam int SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  // Recognizer context; S3 is absorbing once the 01,10,11 pattern completes.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/counting_arb_if.sv
// ---------------------------------------------------------------------------
// counting_arb_if : requester handshake and detection bus for counting_arb.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface counting_arb_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [2*NCH-1:0] req_num;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   hit;
  logic             det_pulse;
  logic [CW-1:0]    det_ch;

  modport master (
    output req_valid,
    output req_num,
    output clr,
    input  req_ready,
    input  hit,
    input  det_pulse,
    input  det_ch
  );

  modport slave (
    input  req_valid,
    input  req_num,
    input  clr,
    output req_ready,
    output hit,
    output det_pulse,
    output det_ch
  );

endinterface

`default_nettype wire

// File: rtl/counting_next.sv
// ---------------------------------------------------------------------------
// counting_next : combinational next-context function for one accepted symbol.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counting_next
  import counting_pkg::*;
(
  input  state_t cur_state,
  input  sym_t   num,
  output state_t nxt_state
);

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S0: begin
        if (num == 2'b01) nxt_state = S1;
      end
      S1: begin
        if (num == 2'b10)      nxt_state = S2;
        else if (num == 2'b11) nxt_state = S0;
      end
      S2: begin
        case (num)
          2'b01:   nxt_state = S1;
          2'b10:   nxt_state = S0;
          2'b11:   nxt_state = S3;
          default: nxt_state = S2;
        endcase
      end
      default: nxt_state = cur_state;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/counting_arb.sv
// ---------------------------------------------------------------------------
// counting_arb : round-robin sharing of one symbol recognizer among NCH
//                requesters. Optional COUNTING_ARB_LOCK_EN masks S3 channels.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counting_arb
  import counting_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  counting_arb_if.slave  bus
);

  localparam int CW = $clog2(NCH);

  state_t           ctx_q [NCH];
  state_t           ctx_d [NCH];
  logic [CW-1:0]    ptr_q;
  logic [CW-1:0]    ptr_d;
  logic [NCH-1:0]   hit_q;
  logic [NCH-1:0]   hit_d;
  logic             det_pulse_q;
  logic             det_pulse_d;
  logic [CW-1:0]    det_ch_q;
  logic [CW-1:0]    det_ch_d;

  logic [NCH-1:0]   eligible;
  logic             grant_found;
  logic [CW-1:0]    grant_idx;
  logic [NCH-1:0]   ready_w;
  state_t           cur_ctx;
  state_t           nxt_ctx;
  sym_t             grant_sym;

`ifdef COUNTING_ARB_LOCK_EN
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = bus.req_valid[i] & (ctx_q[i] != S3);
    end
  end
`else
  assign eligible = bus.req_valid;
`endif

  // First eligible channel at or above ptr, wrapping at NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      logic [CW:0] cand;
      cand = {1'b0, ptr_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
      if (!grant_found && eligible[cand[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CW-1:0];
      end
    end
  end

  always_comb begin
    ready_w = '0;
    if (grant_found && rst_n) ready_w[grant_idx] = 1'b1;
  end

  assign cur_ctx   = ctx_q[grant_idx];
  assign grant_sym = bus.req_num[{grant_idx, 1'b0} +: 2];

  counting_next u_next (
    .cur_state (cur_ctx),
    .num       (grant_sym),
    .nxt_state (nxt_ctx)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) ctx_d[i] = ctx_q[i];
    ptr_d       = ptr_q;
    det_pulse_d = 1'b0;
    det_ch_d    = det_ch_q;

    if (grant_found) begin
      ctx_d[grant_idx] = nxt_ctx;
      ptr_d = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + 1'b1;
      if (cur_ctx == S2 && nxt_ctx == S3 && !bus.clr[grant_idx]) begin
        det_pulse_d = 1'b1;
        det_ch_d    = grant_idx;
      end
    end

    // Clear wins over a same-cycle transfer; the symbol is still consumed.
    for (int i = 0; i < NCH; i++) begin
      if (bus.clr[i]) ctx_d[i] = S0;
      hit_d[i] = (ctx_d[i] == S3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
      ptr_q       <= '0;
      hit_q       <= '0;
      det_pulse_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
      ptr_q       <= ptr_d;
      hit_q       <= hit_d;
      det_pulse_q <= det_pulse_d;
      det_ch_q    <= det_ch_d;
    end
  end

  assign bus.req_ready = ready_w;
  assign bus.hit       = hit_q;
  assign bus.det_pulse = det_pulse_q;
  assign bus.det_ch    = det_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_counting_arb.sv
// ---------------------------------------------------------------------------
// tb_counting_arb : self-checking bench for counting_arb against a table model.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counting_arb;

  localparam int NCH = 4;
  localparam int CW  = $clog2(NCH);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  counting_arb_if #(.NCH(NCH)) bus ();

  counting_arb #(.NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pattern 01,10,11 recognizer as a lookup table.
  int m_tbl [4][4];
  int m_ctx [NCH];
  int m_ptr;
  bit m_det;
  int m_detch;

  function automatic bit m_lock_masked(int ch);
`ifdef COUNTING_ARB_LOCK_EN
    return m_ctx[ch] == 3;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_grant(logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (v[c] && !m_lock_masked(c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_hit();
    logic [NCH-1:0] h;
    for (int i = 0; i < NCH; i++) h[i] = (m_ctx[i] == 3);
    return h;
  endfunction

  function automatic logic [2*NCH-1:0] pack(int ch, logic [1:0] sym);
    logic [2*NCH-1:0] n;
    n = '0;
    n[2*ch +: 2] = sym;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_ctx[i] = 0;
    m_ptr = 0; m_det = 1'b0; m_detch = 0;
  endtask

  task automatic model_step(int g, logic [2*NCH-1:0] n, logic [NCH-1:0] c);
    m_det = 1'b0;
    if (g >= 0) begin
      int old_s;
      int new_s;
      old_s = m_ctx[g];
      new_s = m_tbl[old_s][int'(n[2*g +: 2])];
      if (old_s == 2 && new_s == 3 && !c[g]) begin
        m_det = 1'b1;
        m_detch = g;
      end
      m_ctx[g] = new_s;
      m_ptr = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) if (c[i]) m_ctx[i] = 0;
  endtask

  // Drives one cycle, samples the combinational grant, advances the model.
  task automatic drive_cycle(input logic [NCH-1:0] v, input logic [2*NCH-1:0] n,
                             input logic [NCH-1:0] c,
                             output logic [NCH-1:0] obs_rdy, output logic [NCH-1:0] exp_rdy);
    int g;
    bus.req_valid = v;
    bus.req_num   = n;
    bus.clr       = c;
    #2;
    obs_rdy = bus.req_ready;
    g = model_grant(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(posedge clk);
    model_step(g, n, c);
    #1;
    bus.req_valid = '0;
    bus.clr       = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_num = '0; bus.clr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1; bus.req_num = '0; bus.clr = '0;
    model_reset();
    @(posedge clk); #1;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    checks++;
    if (bus.hit !== '0) begin errors++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    checks++;
    if (bus.det_pulse !== 1'b0 || bus.det_ch !== '0) begin
      errors++; $display("FAIL reset_det got=%b/%0d exp=0/0", bus.det_pulse, bus.det_ch);
    end
    checks++;
    bus.req_valid = '0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    logic [NCH-1:0] o, e;
    logic [1:0] syms [3];
    syms = '{2'b01, 2'b10, 2'b11};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b0001, pack(0, syms[i]), '0, o, e);
      if (o !== 4'b0001) begin errors++; $display("FAIL single_ready step=%0d got=%b exp=0001", i, o); end
      checks++;
    end
    if (bus.hit !== 4'b0001 || bus.det_pulse !== 1'b1 || bus.det_ch !== CW'(0)) begin
      errors++;
      $display("FAIL single_det got hit=%b det=%b ch=%0d exp hit=0001 det=1 ch=0",
               bus.hit, bus.det_pulse, bus.det_ch);
    end
    checks++;
    drive_cycle('0, '0, '0, o, e);
    if (bus.det_pulse !== 1'b0 || bus.hit !== 4'b0001) begin
      errors++; $display("FAIL single_after got det=%b hit=%b exp det=0 hit=0001", bus.det_pulse, bus.hit);
    end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] o, e, want;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive_cycle('1, '0, '0, o, e);
      want = '0;
      want[i % NCH] = 1'b1;
      if (o !== want) begin errors++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", i, o, want); end
      checks++;
    end
  endtask

  task automatic test_interleave();
    logic [NCH-1:0] o, e, v;
    logic [1:0] q1 [$];
    logic [1:0] q2 [$];
    logic [2*NCH-1:0] n;
    int guard;
    apply_reset();
    q1 = '{2'b01, 2'b10};
    q2 = '{2'b01, 2'b11};
    guard = 0;
    while ((q1.size() > 0 || q2.size() > 0) && guard < 10) begin
      v = '0; n = '0;
      if (q1.size() > 0) begin v[1] = 1'b1; n[3:2] = q1[0]; end
      if (q2.size() > 0) begin v[2] = 1'b1; n[5:4] = q2[0]; end
      drive_cycle(v, n, '0, o, e);
      if (o !== e) begin errors++; $display("FAIL ilv_ready got=%b exp=%b", o, e); end
      checks++;
      if (o[1] && q1.size() > 0) void'(q1.pop_front());
      if (o[2] && q2.size() > 0) void'(q2.pop_front());
      guard++;
    end
    if (guard >= 10) begin errors++; $display("FAIL ilv_timeout got=%0d cycles exp<10", guard); end
    checks++;
    if (bus.hit !== '0) begin errors++; $display("FAIL ilv_hit_mid got=%b exp=0000", bus.hit); end
    checks++;
    drive_cycle(4'b0010, pack(1, 2'b11), '0, o, e);
    if (bus.hit !== 4'b0010 || bus.det_pulse !== 1'b1 || bus.det_ch !== CW'(1)) begin
      errors++;
      $display("FAIL ilv_ch1 got hit=%b det=%b ch=%0d exp hit=0010 det=1 ch=1", bus.hit, bus.det_pulse, bus.det_ch);
    end
    checks++;
    drive_cycle(4'b0100, pack(2, 2'b11), '0, o, e);
    if (bus.hit !== 4'b0010 || bus.det_pulse !== 1'b0 || bus.det_ch !== CW'(1)) begin
      errors++;
      $display("FAIL ilv_ch2 got hit=%b det=%b ch=%0d exp hit=0010 det=0 ch=1", bus.hit, bus.det_pulse, bus.det_ch);
    end
    checks++;
  endtask

  task automatic test_clr_priority();
    logic [NCH-1:0] o, e;
    apply_reset();
    drive_cycle(4'b1000, pack(3, 2'b01), '0, o, e);
    drive_cycle(4'b1000, pack(3, 2'b10), '0, o, e);
    drive_cycle(4'b1000, pack(3, 2'b11), 4'b1000, o, e);
    if (o !== 4'b1000) begin errors++; $display("FAIL clr_ready got=%b exp=1000", o); end
    checks++;
    if (bus.det_pulse !== 1'b0 || bus.hit !== '0) begin
      errors++; $display("FAIL clr_det got det=%b hit=%b exp det=0 hit=0000", bus.det_pulse, bus.hit);
    end
    checks++;
    drive_cycle(4'b1000, pack(3, 2'b11), '0, o, e);
    if (bus.hit !== '0) begin errors++; $display("FAIL clr_s0 got=%b exp=0000", bus.hit); end
    checks++;
    drive_cycle(4'b1000, pack(3, 2'b01), '0, o, e);
    drive_cycle(4'b1000, pack(3, 2'b10), '0, o, e);
    drive_cycle(4'b1000, pack(3, 2'b11), '0, o, e);
    if (bus.hit !== 4'b1000 || bus.det_pulse !== 1'b1 || bus.det_ch !== CW'(3)) begin
      errors++;
      $display("FAIL clr_redet got hit=%b det=%b ch=%0d exp hit=1000 det=1 ch=3", bus.hit, bus.det_pulse, bus.det_ch);
    end
    checks++;
  endtask

  task automatic test_reset_midstream();
    logic [NCH-1:0] o, e;
    apply_reset();
    drive_cycle(4'b0010, pack(1, 2'b01), '0, o, e);
    drive_cycle(4'b0010, pack(1, 2'b10), '0, o, e);
    drive_cycle(4'b0010, pack(1, 2'b11), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b01), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b10), '0, o, e);
    bus.req_valid = 4'b0011;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (bus.hit !== '0 || bus.det_pulse !== 1'b0 || bus.det_ch !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL midrst_out got hit=%b det=%b ch=%0d rdy=%b exp all 0",
               bus.hit, bus.det_pulse, bus.det_ch, bus.req_ready);
    end
    checks++;
    bus.req_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive_cycle(4'b0011, pack(0, 2'b11) | pack(1, 2'b11), '0, o, e);
    if (o !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got=%b exp=0001", o); end
    checks++;
    if (bus.hit !== '0 || bus.det_pulse !== 1'b0) begin
      errors++; $display("FAIL midrst_ctx got hit=%b det=%b exp 0/0", bus.hit, bus.det_pulse);
    end
    checks++;
  endtask

`ifdef COUNTING_ARB_LOCK_EN
  task automatic test_lock();
    logic [NCH-1:0] o, e;
    apply_reset();
    drive_cycle(4'b0001, pack(0, 2'b01), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b10), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b11), '0, o, e);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b0011, '0, '0, o, e);
      if (o !== 4'b0010) begin errors++; $display("FAIL lock_mask cyc=%0d got=%b exp=0010", i, o); end
      checks++;
    end
    drive_cycle(4'b0010, '0, 4'b0001, o, e);
    drive_cycle(4'b0011, '0, '0, o, e);
    if (o !== 4'b0001) begin errors++; $display("FAIL lock_release got=%b exp=0001", o); end
    checks++;
  endtask
`else
  task automatic test_s3_absorb();
    logic [NCH-1:0] o, e;
    apply_reset();
    drive_cycle(4'b0001, pack(0, 2'b01), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b10), '0, o, e);
    drive_cycle(4'b0001, pack(0, 2'b11), '0, o, e);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(4'b0001, pack(0, 2'(i)), '0, o, e);
      if (o !== 4'b0001 || bus.hit !== 4'b0001 || bus.det_pulse !== 1'b0) begin
        errors++;
        $display("FAIL s3_absorb sym=%0d got rdy=%b hit=%b det=%b exp 0001/0001/0", i, o, bus.hit, bus.det_pulse);
      end
      checks++;
    end
  endtask
`endif

  task automatic test_random();
    logic [NCH-1:0] o, e, v, c;
    logic [2*NCH-1:0] n;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v = NCH'($urandom);
      n = (2*NCH)'($urandom);
      c = '0;
      if ($urandom_range(0, 11) == 0) c[$urandom_range(0, NCH-1)] = 1'b1;
      drive_cycle(v, n, c, o, e);
      if (o !== e) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, o, e); end
      checks++;
      if (bus.hit !== exp_hit()) begin errors++; $display("FAIL rand_hit cyc=%0d got=%b exp=%b", i, bus.hit, exp_hit()); end
      checks++;
      if (bus.det_pulse !== m_det || bus.det_ch !== CW'(m_detch)) begin
        errors++;
        $display("FAIL rand_det cyc=%0d got=%b/%0d exp=%b/%0d", i, bus.det_pulse, bus.det_ch, m_det, m_detch);
      end
      checks++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    m_tbl = '{'{0, 1, 0, 0}, '{1, 1, 2, 0}, '{2, 1, 0, 3}, '{3, 3, 3, 3}};
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_num = '0; bus.clr = '0;
    model_reset();
    test_reset();
    test_single_channel();
    test_round_robin();
    test_interleave();
    test_clr_priority();
    test_reset_midstream();
`ifdef COUNTING_ARB_LOCK_EN
    test_lock();
`else
    test_s3_absorb();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counting_arb.md
# counting_arb

Round-robin scheduler that shares one 2-bit-symbol sequence-recognition datapath among NCH independent requesters. Each requester streams 2-bit symbols through a valid/ready handshake. The block holds a private recognizer context (S0..S3) per channel and advances only the granted channel's context each cycle. It sits between the symbol sources and the rest of the design, exposing per-channel sticky hit flags and a one-cycle detection event.

## Interface
- NCH, default 4: number of requester channels, 2..16.
- CW, default $clog2(NCH): channel index width (derived, not overridable).
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NCH: bit i asserts that channel i has a symbol.
- req_num, input, 2*NCH: channel i symbol is in bits [2i+1:2i].
- req_ready, output, NCH: one-hot-or-zero grant. Transfer on channel i when req_valid[i] & req_ready[i].
- clr, input, NCH: bit i synchronously returns channel i context to S0.
- hit, output, NCH: bit i is 1 while channel i context is S3 (registered).
- det_pulse, output, 1: one-cycle pulse when some channel entered S3.
- det_ch, output, CW: channel that entered S3; valid with det_pulse.

## Operation
- Per-channel context transitions per accepted symbol (symbol not listed = stay):
  - S0: 01 goes to S1.
  - S1: 10 goes to S2; 11 goes to S0.
  - S2: 01 goes to S1; 10 goes to S0; 11 goes to S3.
  - S3: absorbing.
- Arbitration:
  - Round-robin pointer ptr (CW bits, wraps NCH-1 to 0).
  - Grant goes to the first channel with req_valid set, searching from ptr upward with wrap.
  - req_ready is combinational from req_valid and ptr. It never depends on ready of another block.
  - At most one transfer per cycle.
- After a transfer on channel g, ptr becomes g+1 mod NCH. With no transfer, ptr holds.
- Only the granted channel's context changes. All other contexts are untouched.
- clr[i] has priority over a simultaneous transfer on channel i. The symbol is consumed (handshake completes) and discarded, and the context becomes S0.
- Multiple clr bits may be set in one cycle. Each affects only its own channel.
- det_pulse/det_ch:
  - Set the cycle after a transfer that moves a context from S2 to S3, unless clr was set for that channel in the same cycle.
  - Never set for a transfer while already in S3.
- When not pulsing, det_ch holds its last value.

## Timing
- Reset values: all contexts S0, ptr 0, hit 0, det_pulse 0, det_ch 0.
- req_ready reflects the current cycle's req_valid and ptr. It is 0 during reset.
- Latency: a symbol accepted at edge k is reflected in hit and det_pulse after edge k (visible in cycle k+1).
- Throughput: one symbol per cycle aggregate. With M channels continuously valid, each channel is granted once every M cycles.
- Reset asserted mid-stream discards all contexts and the pointer immediately. The first cycle after release behaves as after power-up.
- A channel holding req_valid without a grant must keep req_num stable. The block does not check this.

## Configuration
- COUNTING_ARB_LOCK_EN defined:
  - A channel whose context is S3 is masked from arbitration: req_ready[i]=0 and the channel is skipped by the round-robin search.
  - Masking lasts until clr[i].
- COUNTING_ARB_LOCK_EN undefined: S3 channels are still granted. Their symbols are consumed with no state change.

## Structure
- Package counting_pkg: 2-bit state encodings S0=00, S1=01, S2=10, S3=11.
- Sub-module counting_next: purely combinational next-state function (state, num) to next_state. It is instantiated once on the granted channel's context; not replicated per channel.
- Top holds the context array, ptr, arbiter search logic, and det registers.

## Test plan
- Reset, then channel 0 alone sends 01,10,11 → hit[0]=1 and det_pulse=1 with det_ch=0 one cycle after the third transfer; hit elsewhere 0.
- All four channels valid every cycle → grants 0,1,2,3,0,… in successive cycles; after the first grant to 2, ptr=3.
- Ch1 sends 01,10 and ch2 sends 01,11 interleaved → ch1 context S2, ch2 context S0; no cross-talk; then ch1 sends 11 → hit[1]=1 only.
- Ch3 in S2, clr[3] and symbol 11 in the same cycle → transfer completes, context S0, no det_pulse, hit[3]=0.
- rst_n dropped for 1 cycle with ch0 in S2 → all outputs 0 immediately; after release ch0 sending 11 stays S0.
- With COUNTING_ARB_LOCK_EN, ch0 in S3 and ch0, ch1 valid → req_ready never grants ch0; after clr[0], ch0 granted again.
